// File: rtl/vga_sync_rx.sv
// VGA sync receiver: recovers (hc,vc) from hsync/vsync, verifies timing/lock, captures one probed pixel.
// Latency: input to px 2 cycles, to probe_color 3 cycles; no backpressure (free-running pixel stream).
module vga_sync_rx #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  hc,
  output logic [9:0]  vc,
  output logic        locked,
  output logic        frame_start,
  output logic [11:0] probe_color,
  output logic        probe_valid,
  output logic [7:0]  err_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam int TO_W = $clog2(2 * H_TOTAL);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(2 * H_TOTAL - 1);
  localparam int CW = $clog2(LOCK_FRAMES + 1);

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pix_t;

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  logic            hs1, hs2, vs1, vs2;
  pix_t            rgb1, px;
  state_t          state, state_nxt;
  logic [CW-1:0]   clean_cnt, clean_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [9:0]      hc_nxt, vc_nxt;
  logic            hs_fall, vs_fall, h_wrap;
  logic            h_err, v_err, timeout, any_err, probe_hit;

  assign hs_fall = hs2 & ~hs1;
  assign vs_fall = vs2 & ~vs1;

  // Predicted counters: where (hc,vc) would land without any sync edge.
  assign hc_nxt = (hc == H_LAST) ? '0 : hc + 10'd1;
  assign h_wrap = (hc == H_LAST) && !hs_fall;
  assign vc_nxt = h_wrap ? ((vc == V_LAST) ? '0 : vc + 10'd1) : vc;

  assign h_err   = hs_fall && (hc_nxt != HS_START);
  assign v_err   = vs_fall && (vc_nxt != VS_START);
  assign timeout = !hs_fall && (to_cnt == TO_LAST);
  assign any_err = h_err | v_err | timeout;

  assign probe_hit = locked && (hc == probe_x) && (vc == probe_y) &&
                     (probe_x < H_VIS) && (probe_y < V_VIS);

  always_comb begin
    state_nxt = state;
    clean_nxt = clean_cnt;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_nxt = VERIFY;
          clean_nxt = '0;
        end
      end
      VERIFY: begin
        if (any_err) begin
          state_nxt = SEARCH;
        end else if (vs_fall) begin
          clean_nxt = clean_cnt + CW'(1);
          if (clean_cnt == CW'(LOCK_FRAMES - 1)) state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (any_err) state_nxt = SEARCH;
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs1         <= 1'b1;
      hs2         <= 1'b1;
      vs1         <= 1'b1;
      vs2         <= 1'b1;
      rgb1        <= '0;
      px          <= '0;
      hc          <= '0;
      vc          <= '0;
      to_cnt      <= '0;
      state       <= SEARCH;
      clean_cnt   <= '0;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      probe_color <= '0;
      probe_valid <= 1'b0;
      err_count   <= '0;
    end else begin
      hs1  <= hsync;
      hs2  <= hs1;
      vs1  <= vsync;
      vs2  <= vs1;
      rgb1 <= '{r: red, g: green, b: blue};
      px   <= rgb1;

      hc <= hs_fall ? HS_START : hc_nxt;
      vc <= vs_fall ? VS_START : vc_nxt;

      // Restart after a timeout so a dead link keeps reporting errors.
      to_cnt <= (hs_fall || timeout) ? '0 : to_cnt + TO_W'(1);

      state     <= state_nxt;
      clean_cnt <= clean_nxt;
      locked    <= (state_nxt == LOCKED);

      if (state != SEARCH && any_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;

      frame_start <= locked && (hc == '0) && (vc == '0);

      probe_valid <= probe_hit;
      if (probe_hit) probe_color <= px;
    end
  end

endmodule
